// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared motion-estimation types, constants and helpers
package me_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_READY   = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_DONE    = 3'd4
    } me_state_t;

    // Window geometry shared with the PE array and the SRAM wrapper.
    localparam int ME_NUM_BANKS  = 32;
    localparam int ME_GRP_BANKS  = 4;
    localparam int ME_DEPTH      = 96;
    localparam int ME_ADDR_W     = 7;
    localparam int ME_PRIME_ROWS = 4;

    // Read-mux encoding that routes the reference window to the PE array.
    localparam int ME_SEL_W      = 4;
    localparam int ME_PRIME_SEL  = 4;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int me_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ref_wr_seq.sv
// rtl/ref_wr_seq.sv - preload write sequencer: group/row counters and bank addressing
module ref_wr_seq #(
    parameter int NUM_BANKS = 32,
    parameter int GRP_BANKS = 4,
    parameter int DEPTH     = 96,
    parameter int ADDR_W    = 7,
    parameter int GRP_W     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clr,
    input  logic                        i_active,
    input  logic                        i_wr_valid,
    output logic                        o_wr_ready,
    output logic                        o_wr_en,
    output logic [NUM_BANKS-1:0]        o_bank_sel,
    output logic [NUM_BANKS*ADDR_W-1:0] o_wr_addr_all,
    output logic [GRP_W-1:0]            o_grp,
    output logic [ADDR_W-1:0]           o_row,
    output logic                        o_last_beat
);

    localparam int                   NUM_GRPS = NUM_BANKS / GRP_BANKS;
    localparam logic [NUM_BANKS-1:0] GRP_MASK = NUM_BANKS'((64'd1 << GRP_BANKS) - 64'd1);
    localparam logic [GRP_W-1:0]     LAST_GRP = GRP_W'(NUM_GRPS - 1);
    localparam logic [ADDR_W-1:0]    LAST_ROW = ADDR_W'(DEPTH - 1);

    logic [GRP_W-1:0]  r_grp;
    logic [ADDR_W-1:0] r_row;
    logic              w_beat;
    logic              w_row_wrap;
    logic              w_grp_last;

    assign w_beat     = i_wr_valid & i_active;
    assign w_row_wrap = (r_row == LAST_ROW);
    assign w_grp_last = (r_grp == LAST_GRP);

    // Counters advance only on an accepted row; they sit at zero whenever preload is not running.
    always_ff @(posedge clk) begin
        if (rst || i_clr || !i_active) begin
            r_grp <= '0;
            r_row <= '0;
        end else if (w_beat) begin
            if (w_row_wrap) begin
                r_row <= '0;
                r_grp <= w_grp_last ? '0 : r_grp + 1'b1;
            end else begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    assign o_wr_ready    = i_active;
    assign o_wr_en       = w_beat;
    assign o_bank_sel    = i_active ? (GRP_MASK << (int'(r_grp) * GRP_BANKS)) : '0;
    assign o_wr_addr_all = {NUM_BANKS{r_row}};
    assign o_grp         = r_grp;
    assign o_row         = r_row;
    assign o_last_beat   = w_beat & w_row_wrap & w_grp_last;

endmodule

// File: rtl/ref_mem_ctrl_gen.sv
// rtl/ref_mem_ctrl_gen.sv - reference-window controller: preload, prime and row streaming
module ref_mem_ctrl_gen
    import me_pkg::*;
#(
    parameter int NUM_BANKS  = ME_NUM_BANKS,
    parameter int GRP_BANKS  = ME_GRP_BANKS,
    parameter int DEPTH      = ME_DEPTH,
    parameter int ADDR_W     = ME_ADDR_W,
    parameter int PRIME_ROWS = ME_PRIME_ROWS,
    parameter int SEL_W      = ME_SEL_W,
    parameter int PRIME_SEL  = ME_PRIME_SEL
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_pre,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic                        wr_en,
    output logic [NUM_BANKS-1:0]        bank_sel,
    output logic [NUM_BANKS*ADDR_W-1:0] wr_addr_all,
    input  logic [ADDR_W-1:0]           search_rows,
    input  logic                        search_go,
    input  logic                        pe_ready,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    output logic [SEL_W-1:0]            rd_sel,
    output logic                        busy,
    output logic                        done,
    input  logic                        abort
);

    localparam int                NUM_GRPS    = NUM_BANKS / GRP_BANKS;
    localparam int                GRP_W       = (NUM_GRPS > 1) ? me_clog2(NUM_GRPS) : 1;
    localparam logic [GRP_W-1:0]  LAST_GRP    = GRP_W'(NUM_GRPS - 1);
    localparam logic [ADDR_W-1:0] PRIME_BASE  = ADDR_W'(DEPTH - PRIME_ROWS);
    localparam logic [ADDR_W-1:0] PRIME_START = ADDR_W'(PRIME_ROWS % DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ROW    = ADDR_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0]  SEL_PE      = SEL_W'(PRIME_SEL);

    me_state_t         r_state;
    me_state_t         w_next;
    logic [ADDR_W-1:0] r_n;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_beat_cnt;

    logic              w_active;
    logic [GRP_W-1:0]  w_grp;
    logic [ADDR_W-1:0] w_row;
    logic              w_last_beat;
    logic              w_prime;
    logic              w_rd_beat;

    assign w_active  = (r_state == ST_PRELOAD);
    assign w_prime   = (PRIME_ROWS > 0) && w_active && (w_grp == LAST_GRP) && (w_row >= PRIME_BASE);
    assign w_rd_beat = (r_state == ST_SEARCH) && pe_ready;

    ref_wr_seq #(
        .NUM_BANKS (NUM_BANKS),
        .GRP_BANKS (GRP_BANKS),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .GRP_W     (GRP_W)
    ) u_wr_seq (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (abort),
        .i_active      (w_active),
        .i_wr_valid    (wr_valid),
        .o_wr_ready    (wr_ready),
        .o_wr_en       (wr_en),
        .o_bank_sel    (bank_sel),
        .o_wr_addr_all (wr_addr_all),
        .o_grp         (w_grp),
        .o_row         (w_row),
        .o_last_beat   (w_last_beat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Search row count, read pointer and beat counter; restarted on every accepted search_go.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_n        <= '0;
            r_rd_cnt   <= '0;
            r_beat_cnt <= '0;
        end else if ((r_state == ST_READY) && search_go) begin
            r_n        <= (search_rows == '0) ? ADDR_W'(1) : search_rows;
            r_rd_cnt   <= PRIME_START;
            r_beat_cnt <= '0;
        end else if (w_rd_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_rd_cnt   <= (r_rd_cnt == LAST_ROW) ? '0 : r_rd_cnt + 1'b1;
        end
    end

    // Next-state and read-side outputs; abort overrides every transition.
    always_comb begin
        w_next  = r_state;
        rd_en   = 1'b0;
        rd_addr = '0;
        rd_sel  = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_pre) begin
                    w_next = ST_PRELOAD;
                end
            end
            ST_PRELOAD: begin
                busy = 1'b1;
                if (w_prime) begin
                    rd_en   = wr_valid;
                    rd_addr = w_row - PRIME_BASE;
                    rd_sel  = SEL_PE;
                end
                if (w_last_beat) begin
                    w_next = ST_READY;
                end
            end
            ST_READY: begin
                rd_sel = SEL_PE;
                if (search_go) begin
                    w_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                busy    = 1'b1;
                rd_en   = pe_ready;
                rd_addr = r_rd_cnt;
                rd_sel  = SEL_PE;
                if (pe_ready && (r_beat_cnt == r_n - 1'b1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                rd_sel = SEL_PE;
                w_next = ST_READY;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_next = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_ref_mem_ctrl_gen.sv
// tb/tb_ref_mem_ctrl_gen.sv - directed self-checking bench for ref_mem_ctrl_gen
module tb_ref_mem_ctrl_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_pre = 1'b0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic         wr_en;
    logic [31:0]  bank_sel;
    logic [223:0] wr_addr_all;
    logic [6:0]   search_rows = 7'd0;
    logic         search_go = 1'b0;
    logic         pe_ready = 1'b0;
    logic         rd_en;
    logic [6:0]   rd_addr;
    logic [3:0]   rd_sel;
    logic         busy;
    logic         done;
    logic         abort = 1'b0;

    int errors = 0;
    int checks = 0;

    ref_mem_ctrl_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start_pre   (start_pre),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_en       (wr_en),
        .bank_sel    (bank_sel),
        .wr_addr_all (wr_addr_all),
        .search_rows (search_rows),
        .search_go   (search_go),
        .pe_ready    (pe_ready),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_sel      (rd_sel),
        .busy        (busy),
        .done        (done),
        .abort       (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_mask(input int beat);
        logic [31:0] m;
        m = 32'hF;
        return m << (4 * (beat / 96));
    endfunction

    function automatic logic [223:0] exp_addr(input int row);
        logic [6:0] r;
        r = 7'(row);
        return {32{r}};
    endfunction

    initial begin
        int k;
        int c;

        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_bank_sel", bank_sel, 0);
        chk("rst_wr_addr", wr_addr_all, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_sel", rd_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Full preload with wr_valid held high, including the prime reads
        wr_valid  = 1'b1;
        start_pre = 1'b1;
        cyc();
        start_pre = 1'b0;
        chk("pre_wr_ready_latency", wr_ready, 1);
        for (int b = 0; b < 768; b++) begin
            chk("pre_wr_en", wr_en, 1);
            chk("pre_busy", busy, 1);
            chk("pre_bank_sel", bank_sel, exp_mask(b));
            chk("pre_wr_addr", wr_addr_all, exp_addr(b % 96));
            chk("pre_rd_en", rd_en, (b >= 764) ? 1 : 0);
            if (b >= 764) begin
                chk("prime_rd_addr", rd_addr, b - 764);
                chk("prime_rd_sel", rd_sel, 4);
            end
            cyc();
        end
        chk("ready_wr_en", wr_en, 0);
        chk("ready_wr_ready", wr_ready, 0);
        chk("ready_bank_sel", bank_sel, 0);
        chk("ready_busy", busy, 0);
        chk("ready_rd_sel", rd_sel, 4);
        chk("ready_rd_en", rd_en, 0);

        // Abort from READY, then preload with wr_valid toggling
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_ready_busy", busy, 0);
        chk("abort_ready_rd_sel", rd_sel, 0);
        wr_valid  = 1'b0;
        start_pre = 1'b1;
        cyc();
        start_pre = 1'b0;
        k = 0;
        c = 0;
        while (k < 768 && c < 2000) begin
            wr_valid = (c % 2 == 0);
            #1;
            chk("tog_busy", busy, 1);
            chk("tog_wr_en", wr_en, wr_valid);
            chk("tog_rd_en", rd_en, (wr_valid && k >= 764) ? 1 : 0);
            if (wr_valid) begin
                chk("tog_bank_sel", bank_sel, exp_mask(k));
                chk("tog_wr_addr", wr_addr_all, exp_addr(k % 96));
                if (k >= 764) begin
                    chk("tog_prime_addr", rd_addr, k - 764);
                end
                k++;
            end
            cyc();
            c++;
        end
        chk("tog_beats_done", k, 768);
        chk("tog_ready_busy", busy, 0);
        chk("tog_ready_wr_ready", wr_ready, 0);

        // Search 95 rows with pe_ready low every third cycle; start_pre mid-search is ignored
        wr_valid    = 1'b0;
        search_rows = 7'd95;
        search_go   = 1'b1;
        cyc();
        search_go = 1'b0;
        k = 0;
        c = 0;
        while (k < 95 && c < 500) begin
            pe_ready  = (c % 3 != 2);
            start_pre = (c == 5);
            #1;
            chk("srch_rd_en", rd_en, pe_ready);
            chk("srch_done", done, 0);
            chk("srch_busy", busy, 1);
            chk("srch_wr_ready", wr_ready, 0);
            if (pe_ready) begin
                chk("srch_rd_addr", rd_addr, (4 + k) % 96);
                chk("srch_rd_sel", rd_sel, 4);
                k++;
            end
            cyc();
            c++;
        end
        start_pre = 1'b0;
        pe_ready  = 1'b0;
        #1;
        chk("srch_beats", k, 95);
        chk("srch_done_pulse", done, 1);
        chk("srch_done_rd_en", rd_en, 0);
        cyc();
        chk("srch_done_clear", done, 0);
        chk("srch_back_ready", busy, 0);
        chk("srch_ready_sel", rd_sel, 4);

        // search_rows=0 streams exactly one row from PRIME_ROWS
        search_rows = 7'd0;
        pe_ready    = 1'b1;
        search_go   = 1'b1;
        cyc();
        search_go = 1'b0;
        chk("zero_rd_en", rd_en, 1);
        chk("zero_rd_addr", rd_addr, 4);
        cyc();
        chk("zero_done", done, 1);
        chk("zero_rd_en_after", rd_en, 0);
        cyc();
        chk("zero_done_clear", done, 0);
        chk("zero_ready", busy, 0);

        // search_go in IDLE is ignored
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        search_go = 1'b1;
        cyc();
        search_go = 1'b0;
        chk("idle_go_busy", busy, 0);
        chk("idle_go_rd_en", rd_en, 0);
        chk("idle_go_rd_sel", rd_sel, 0);

        // Abort at preload beat 300, then restart from group 0 row 0
        wr_valid  = 1'b1;
        start_pre = 1'b1;
        cyc();
        start_pre = 1'b0;
        repeat (300) cyc();
        abort = 1'b1;
        #1;
        chk("ab300_wr_en", wr_en, 1);
        chk("ab300_bank_sel", bank_sel, 32'h0000F000);
        chk("ab300_wr_addr", wr_addr_all, exp_addr(12));
        cyc();
        abort = 1'b0;
        chk("ab_wr_ready", wr_ready, 0);
        chk("ab_bank_sel", bank_sel, 0);
        chk("ab_wr_addr", wr_addr_all, 0);
        chk("ab_busy", busy, 0);
        start_pre = 1'b1;
        cyc();
        start_pre = 1'b0;
        chk("restart_bank_sel", bank_sel, 32'h0000000F);
        chk("restart_wr_addr", wr_addr_all, 0);
        chk("restart_wr_ready", wr_ready, 1);
        repeat (768) cyc();
        chk("restart_ready", busy, 0);

        // rst at SEARCH beat 10
        wr_valid    = 1'b0;
        search_rows = 7'd50;
        pe_ready    = 1'b1;
        search_go   = 1'b1;
        cyc();
        search_go = 1'b0;
        repeat (10) cyc();
        chk("b10_rd_addr", rd_addr, 14);
        chk("b10_rd_en", rd_en, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        pe_ready = 1'b0;
        #1;
        chk("rst_srch_busy", busy, 0);
        chk("rst_srch_rd_en", rd_en, 0);
        chk("rst_srch_rd_sel", rd_sel, 0);
        chk("rst_srch_rd_addr", rd_addr, 0);
        wr_valid  = 1'b1;
        start_pre = 1'b1;
        cyc();
        start_pre = 1'b0;
        chk("rst_restart_bank_sel", bank_sel, 32'h0000000F);
        chk("rst_restart_wr_addr", wr_addr_all, 0);
        chk("rst_restart_wr_ready", wr_ready, 1);
        chk("rst_restart_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
